// File: rtl/ac_dc_extract.sv
// Per-LED AC (peak-to-peak) and DC (mean) extraction over windows of 2^WIN_LOG2 sample pairs.
// Optional build macro ACDC_CLIP_EN: windows containing a rail sample are dropped and flagged on clip_flag.
module ac_dc_extract #(
  parameter int WIN_LOG2 = 9,
  parameter int DW       = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                acq_en,
  input  logic                sample_dv,
  input  logic [DW-1:0]       led1_sample,
  input  logic [DW-1:0]       led2_sample,
  output logic [DW-1:0]       led1_AC_computed,
  output logic [DW-1:0]       led1_DC_computed,
  output logic [DW-1:0]       led2_AC_computed,
  output logic [DW-1:0]       led2_DC_computed,
  output logic                final_comp_dv,
  output logic [WIN_LOG2-1:0] win_cnt
`ifdef ACDC_CLIP_EN
  ,
  output logic                clip_flag
`endif
);

  localparam int SW = DW + WIN_LOG2;
  localparam logic [DW-1:0] DC_MIN = {{(DW-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic [SW-1:0]       sum1_q, sum1_d, sum2_q, sum2_d;
  logic [DW-1:0]       max1_q, max1_d, min1_q, min1_d;
  logic [DW-1:0]       max2_q, max2_d, min2_q, min2_d;
  logic [DW-1:0]       l1_ac_q, l1_ac_d, l1_dc_q, l1_dc_d;
  logic [DW-1:0]       l2_ac_q, l2_ac_d, l2_dc_q, l2_dc_d;
  logic                dv_q, dv_d;

  // Running values with the current sample folded in; these feed both the
  // accumulators and, at window close, the result registers.
  logic                accept, win_close, clipped;
  logic [SW-1:0]       sum1_n, sum2_n;
  logic [DW-1:0]       max1_n, min1_n, max2_n, min2_n;
  logic [DW-1:0]       dc1_raw, dc2_raw;

  assign accept    = acq_en & sample_dv;
  assign win_close = accept && (win_cnt_q == '1);

  assign sum1_n = sum1_q + SW'(led1_sample);
  assign sum2_n = sum2_q + SW'(led2_sample);
  assign max1_n = (led1_sample > max1_q) ? led1_sample : max1_q;
  assign min1_n = (led1_sample < min1_q) ? led1_sample : min1_q;
  assign max2_n = (led2_sample > max2_q) ? led2_sample : max2_q;
  assign min2_n = (led2_sample < min2_q) ? led2_sample : min2_q;

  // Sum of 2^WIN_LOG2 DW-bit samples cannot overflow SW bits; the mean is its top DW bits.
  assign dc1_raw = sum1_n[WIN_LOG2 +: DW];
  assign dc2_raw = sum2_n[WIN_LOG2 +: DW];

`ifdef ACDC_CLIP_EN
  logic clip_mark_q, clip_mark_d;
  logic clip_flag_q, clip_flag_d;
  logic clip_hit;

  assign clip_hit = (led1_sample == '0) || (led1_sample == '1) ||
                    (led2_sample == '0) || (led2_sample == '1);
  assign clipped  = clip_mark_q | clip_hit;
`else
  assign clipped  = 1'b0;
`endif

  // NOTE: every _d gets a default hold/clear value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    sum1_d    = sum1_q;
    sum2_d    = sum2_q;
    max1_d    = max1_q;
    min1_d    = min1_q;
    max2_d    = max2_q;
    min2_d    = min2_q;
    l1_ac_d   = l1_ac_q;
    l1_dc_d   = l1_dc_q;
    l2_ac_d   = l2_ac_q;
    l2_dc_d   = l2_dc_q;
    dv_d      = 1'b0;
`ifdef ACDC_CLIP_EN
    clip_mark_d = clip_mark_q;
    clip_flag_d = 1'b0;
`endif

    case (state_q)
      IDLE:    if (acq_en)  state_d = ACCUM;
      ACCUM:   if (!acq_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!acq_en) begin
      // Partial window discarded; published results are left untouched.
      win_cnt_d = '0;
      sum1_d    = '0;
      sum2_d    = '0;
      max1_d    = '0;
      min1_d    = '1;
      max2_d    = '0;
      min2_d    = '1;
`ifdef ACDC_CLIP_EN
      clip_mark_d = 1'b0;
`endif
    end else if (accept) begin
      win_cnt_d = win_cnt_q + WIN_LOG2'(1);
      sum1_d    = sum1_n;
      sum2_d    = sum2_n;
      max1_d    = max1_n;
      min1_d    = min1_n;
      max2_d    = max2_n;
      min2_d    = min2_n;
`ifdef ACDC_CLIP_EN
      clip_mark_d = clipped;
`endif
      if (win_close) begin
        if (!clipped) begin
          l1_ac_d = max1_n - min1_n;
          l2_ac_d = max2_n - min2_n;
          l1_dc_d = (dc1_raw == '0) ? DC_MIN : dc1_raw;
          l2_dc_d = (dc2_raw == '0) ? DC_MIN : dc2_raw;
          dv_d    = 1'b1;
        end
`ifdef ACDC_CLIP_EN
        clip_flag_d = clipped;
        clip_mark_d = 1'b0;
`endif
        // Next window starts from scratch on the very next sample.
        sum1_d = '0;
        sum2_d = '0;
        max1_d = '0;
        min1_d = '1;
        max2_d = '0;
        min2_d = '1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      win_cnt_q <= '0;
      sum1_q    <= '0;
      sum2_q    <= '0;
      max1_q    <= '0;
      min1_q    <= '1;
      max2_q    <= '0;
      min2_q    <= '1;
      l1_ac_q   <= '0;
      l1_dc_q   <= '0;
      l2_ac_q   <= '0;
      l2_dc_q   <= '0;
      dv_q      <= 1'b0;
`ifdef ACDC_CLIP_EN
      clip_mark_q <= 1'b0;
      clip_flag_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      sum1_q    <= sum1_d;
      sum2_q    <= sum2_d;
      max1_q    <= max1_d;
      min1_q    <= min1_d;
      max2_q    <= max2_d;
      min2_q    <= min2_d;
      l1_ac_q   <= l1_ac_d;
      l1_dc_q   <= l1_dc_d;
      l2_ac_q   <= l2_ac_d;
      l2_dc_q   <= l2_dc_d;
      dv_q      <= dv_d;
`ifdef ACDC_CLIP_EN
      clip_mark_q <= clip_mark_d;
      clip_flag_q <= clip_flag_d;
`endif
    end
  end

  assign led1_AC_computed = l1_ac_q;
  assign led1_DC_computed = l1_dc_q;
  assign led2_AC_computed = l2_ac_q;
  assign led2_DC_computed = l2_dc_q;
  assign final_comp_dv    = dv_q;
  assign win_cnt          = win_cnt_q;
`ifdef ACDC_CLIP_EN
  assign clip_flag        = clip_flag_q;
`endif

endmodule

// File: tb/tb_ac_dc_extract.sv
// Directed bench for ac_dc_extract with an 8-sample window; expected values are hand-computed.
module tb_ac_dc_extract;

  localparam int WIN_LOG2 = 3;
  localparam int DW       = 24;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                acq_en = 1'b0;
  logic                sample_dv = 1'b0;
  logic [DW-1:0]       led1_sample = '0;
  logic [DW-1:0]       led2_sample = '0;
  logic [DW-1:0]       led1_AC_computed, led1_DC_computed;
  logic [DW-1:0]       led2_AC_computed, led2_DC_computed;
  logic                final_comp_dv;
  logic [WIN_LOG2-1:0] win_cnt;
`ifdef ACDC_CLIP_EN
  logic                clip_flag;
`endif

  ac_dc_extract #(.WIN_LOG2(WIN_LOG2), .DW(DW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .acq_en           (acq_en),
    .sample_dv        (sample_dv),
    .led1_sample      (led1_sample),
    .led2_sample      (led2_sample),
    .led1_AC_computed (led1_AC_computed),
    .led1_DC_computed (led1_DC_computed),
    .led2_AC_computed (led2_AC_computed),
    .led2_DC_computed (led2_DC_computed),
    .final_comp_dv    (final_comp_dv),
    .win_cnt          (win_cnt)
`ifdef ACDC_CLIP_EN
    ,
    .clip_flag        (clip_flag)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] e_l1ac = '0, e_l1dc = '0, e_l2ac = '0, e_l2dc = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_results(input string tag);
    check({tag, " l1_ac"}, 32'(led1_AC_computed), 32'(e_l1ac));
    check({tag, " l1_dc"}, 32'(led1_DC_computed), 32'(e_l1dc));
    check({tag, " l2_ac"}, 32'(led2_AC_computed), 32'(e_l2ac));
    check({tag, " l2_dc"}, 32'(led2_DC_computed), 32'(e_l2dc));
  endtask

  // Inputs change on the falling edge; the caller checks outputs at the following falling edge.
  task automatic drive(input logic dv, input logic [DW-1:0] a, input logic [DW-1:0] b);
    sample_dv   = dv;
    led1_sample = a;
    led2_sample = b;
    @(negedge clk);
  endtask

  task automatic set_exp(input logic [DW-1:0] l1ac, input logic [DW-1:0] l1dc,
                         input logic [DW-1:0] l2ac, input logic [DW-1:0] l2dc);
    e_l1ac = l1ac;
    e_l1dc = l1dc;
    e_l2ac = l2ac;
    e_l2dc = l2dc;
  endtask

  logic [DW-1:0] t3_l1 [24];
  logic [DW-1:0] t3_l2 [24];
  logic [DW-1:0] t3_exp [3][4];

  initial begin
    int pulses;

    // Reset held for two cycles.
    @(negedge clk);
    @(negedge clk);
    check("rst dv", 32'(final_comp_dv), 32'd0);
    check("rst win_cnt", 32'(win_cnt), 32'd0);
    check_results("rst");
`ifdef ACDC_CLIP_EN
    check("rst clip_flag", 32'(clip_flag), 32'd0);
`endif
    reset_n = 1'b1;
    acq_en  = 1'b1;
    drive(1'b0, '0, '0);

    // Ramp on IR, flat RED.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DW'((i + 1) * 100), DW'(5000));
      if (i == 4) check("t2 win_cnt mid", 32'(win_cnt), 32'd5);
      if (i < 7) check("t2 no early dv", 32'(final_comp_dv), 32'd0);
    end
    set_exp(DW'(700), DW'(450), DW'(0), DW'(5000));
    check("t2 dv", 32'(final_comp_dv), 32'd1);
    check("t2 win_cnt wrap", 32'(win_cnt), 32'd0);
    check_results("t2");
    drive(1'b0, '0, '0);
    check("t2 dv one cycle", 32'(final_comp_dv), 32'd0);
    check_results("t2 hold");

    // Three back-to-back windows with unrelated data.
    for (int i = 0; i < 8; i++) begin
      t3_l1[i]      = DW'((i + 1) * 10);
      t3_l2[i]      = DW'(1000 + i * 3);
      t3_l1[i + 8]  = DW'(500);
      t3_l2[i + 8]  = (i % 2 == 0) ? DW'(7) : DW'(1);
      t3_l1[i + 16] = DW'(i * i + 1);
      t3_l2[i + 16] = DW'(1048576 + i);
    end
    t3_exp[0][0] = DW'(70);  t3_exp[0][1] = DW'(45);  t3_exp[0][2] = DW'(21); t3_exp[0][3] = DW'(1010);
    t3_exp[1][0] = DW'(0);   t3_exp[1][1] = DW'(500); t3_exp[1][2] = DW'(6);  t3_exp[1][3] = DW'(4);
    t3_exp[2][0] = DW'(49);  t3_exp[2][1] = DW'(18);  t3_exp[2][2] = DW'(7);  t3_exp[2][3] = DW'(1048579);
    pulses = 0;
    for (int k = 0; k < 24; k++) begin
      drive(1'b1, t3_l1[k], t3_l2[k]);
      if (final_comp_dv) pulses++;
      if (k % 8 == 7) begin
        set_exp(t3_exp[k / 8][0], t3_exp[k / 8][1], t3_exp[k / 8][2], t3_exp[k / 8][3]);
        check("t3 dv at close", 32'(final_comp_dv), 32'd1);
        check_results("t3");
      end else begin
        check("t3 dv between", 32'(final_comp_dv), 32'd0);
      end
    end
    check("t3 pulse count", 32'(pulses), 32'd3);
    drive(1'b0, '0, '0);

    // All-zero window: DC clamps to 1 (or the window is clipped when the clip check is built).
    for (int i = 0; i < 8; i++) drive(1'b1, '0, '0);
`ifdef ACDC_CLIP_EN
    check("t4 dv suppressed", 32'(final_comp_dv), 32'd0);
    check("t4 clip_flag", 32'(clip_flag), 32'd1);
`else
    set_exp(DW'(0), DW'(1), DW'(0), DW'(1));
    check("t4 dv", 32'(final_comp_dv), 32'd1);
`endif
    check_results("t4");
    drive(1'b0, '0, '0);

    // Partial window discarded by dropping acq_en.
    for (int i = 0; i < 5; i++) drive(1'b1, DW'(9000), DW'(9000));
    check("t5 win_cnt partial", 32'(win_cnt), 32'd5);
    acq_en = 1'b0;
    drive(1'b1, DW'(9000), DW'(9000));
    check("t5 win_cnt cleared", 32'(win_cnt), 32'd0);
    check("t5 no dv idle", 32'(final_comp_dv), 32'd0);
    drive(1'b1, DW'(9000), DW'(9000));
    check("t5 idle ignores dv", 32'(win_cnt), 32'd0);
    check_results("t5 hold");
    acq_en = 1'b1;
    drive(1'b0, '0, '0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DW'((i + 1) * 2), DW'(300));
      if (i < 7) check("t5 no dv early", 32'(final_comp_dv), 32'd0);
    end
    set_exp(DW'(14), DW'(9), DW'(0), DW'(300));
    check("t5 dv", 32'(final_comp_dv), 32'd1);
    check_results("t5");
    drive(1'b0, '0, '0);

`ifdef ACDC_CLIP_EN
    // One RED sample at full scale drops the window.
    for (int i = 0; i < 8; i++)
      drive(1'b1, DW'(1000), (i == 3) ? {DW{1'b1}} : DW'(1000));
    check("t6 dv suppressed", 32'(final_comp_dv), 32'd0);
    check("t6 clip_flag", 32'(clip_flag), 32'd1);
    check_results("t6 unchanged");
    drive(1'b0, '0, '0);
    check("t6 clip_flag one cycle", 32'(clip_flag), 32'd0);
    for (int i = 0; i < 8; i++) drive(1'b1, DW'(40), DW'(60));
    set_exp(DW'(0), DW'(40), DW'(0), DW'(60));
    check("t6 clean dv", 32'(final_comp_dv), 32'd1);
    check("t6 clean clip_flag", 32'(clip_flag), 32'd0);
    check_results("t6 clean");
    drive(1'b0, '0, '0);
`endif

    // Reset overrides a window close.
    for (int i = 0; i < 7; i++) drive(1'b1, DW'(77), DW'(88));
    reset_n = 1'b0;
    drive(1'b1, DW'(77), DW'(88));
    set_exp('0, '0, '0, '0);
    check("rst2 dv", 32'(final_comp_dv), 32'd0);
    check("rst2 win_cnt", 32'(win_cnt), 32'd0);
    check_results("rst2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
